// File: rtl/control_seq.sv
// control_seq: registered, handshaked instruction decoder.
// Accepts one instruction per valid/ready handshake and presents the decoded
// control word one cycle later. Issue stalls during a multi-cycle multiply and
// while a BNE is unresolved; wrong-path slots after J / taken BNE are dropped.
module control_seq #(
  parameter int REG_ADDR_W  = 5,
  parameter int ADDR_W      = 32,
  parameter int MUL_CYCLES  = 4,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      br_resolve,
  input  logic                      br_taken,
  output logic [3*REG_ADDR_W+9:0]   ctrl,
  output logic                      ctrl_valid,
  output logic [ADDR_W-1:0]         jmp_address,
  output logic                      illegal
);

  localparam int CW      = 3*REG_ADDR_W + 10;
  localparam int CNT_MAX = (MUL_CYCLES > FLUSH_SLOTS) ? MUL_CYCLES : FLUSH_SLOTS;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT = 2'd1;
  localparam logic [1:0] ST_BR_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd40;
  localparam logic [5:0] OP_SW   = 6'd41;
  localparam logic [5:0] OP_BNE  = 6'd42;
  localparam logic [5:0] OP_ADDI = 6'd43;
  localparam logic [5:0] OP_ORI  = 6'd44;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_MUL = 6'd50;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] jmp_address_q, jmp_address_d;

  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] f_rs, f_rt, f_rd, d_rd;
  logic                  d_wr, d_imm, d_mul, d_m2, d_wm, d_wb2, d_br, d_j;
  logic [1:0]            d_alu;
  logic                  d_illegal;
  logic [CW-1:0]         d_word;
  logic [ADDR_W-1:0]     d_jaddr;
  logic                  accept;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign f_rs    = REG_ADDR_W'(instr[25:21]);
  assign f_rt    = REG_ADDR_W'(instr[20:16]);
  assign f_rd    = REG_ADDR_W'(instr[15:11]);
  assign d_jaddr = ADDR_W'(instr[25:0]);

  assign instr_ready = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign accept      = instr_valid & instr_ready;

  // Instruction decode into individual control fields.
  always_comb begin
    d_rd      = '0;
    d_wr      = 1'b0;
    d_imm     = 1'b0;
    d_alu     = 2'b00;
    d_mul     = 1'b0;
    d_m2      = 1'b0;
    d_wm      = 1'b0;
    d_wb2     = 1'b0;
    d_br      = 1'b0;
    d_j       = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OP_LW:   begin d_rd = f_rt; d_wr = 1'b1; d_imm = 1'b1; d_m2 = 1'b1; end
      OP_SW:   begin d_rd = f_rs; d_imm = 1'b1; d_m2 = 1'b1; d_wm = 1'b1; end
      OP_BNE:  begin d_imm = 1'b1; d_alu = 2'b01; d_m2 = 1'b1; d_br = 1'b1; end
      OP_ADDI: begin d_rd = f_rt; d_wr = 1'b1; d_imm = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; end
      OP_ORI:  begin
        d_rd = f_rt; d_wr = 1'b1; d_imm = 1'b1; d_alu = 2'b11; d_m2 = 1'b1; d_wb2 = 1'b1;
      end
      OP_J:    begin d_imm = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; d_j = 1'b1; end
      default: begin
        d_rd = f_rd;
        case (funct)
          FN_ADD:  begin d_wr = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; d_alu = 2'b00; end
          FN_SUB:  begin d_wr = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; d_alu = 2'b01; end
          FN_AND:  begin d_wr = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; d_alu = 2'b10; end
          FN_OR:   begin d_wr = 1'b1; d_m2 = 1'b1; d_wb2 = 1'b1; d_alu = 2'b11; end
          FN_MUL:  begin d_wr = 1'b1; d_mul = 1'b1; d_wb2 = 1'b1; end
          default: d_illegal = 1'b1;
        endcase
      end
    endcase
    d_word = {f_rs, f_rt, d_rd, d_wr, d_imm, d_alu, d_mul, d_m2, d_wm, d_wb2, d_br, d_j};
    if (d_illegal) d_word = '0;
  end

  // Issue FSM and registered output word.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctrl_d        = '0;
    ctrl_valid_d  = 1'b0;
    illegal_d     = 1'b0;
    jmp_address_d = jmp_address_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          ctrl_d       = d_word;
          ctrl_valid_d = 1'b1;
          illegal_d    = d_illegal;
          // A single-cycle multiply needs no stall, so MUL_WAIT is skipped.
          if (d_mul && (MUL_CYCLES > 1)) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end
          if (d_br) state_d = ST_BR_WAIT;
          if (d_j) begin
            jmp_address_d = d_jaddr;
            if (FLUSH_SLOTS > 0) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_W'(FLUSH_SLOTS);
            end
          end
        end
      end
      ST_MUL_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_BR_WAIT: begin
        if (br_resolve) begin
          if (br_taken && (FLUSH_SLOTS > 0)) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_SLOTS);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      ctrl_q        <= '0;
      ctrl_valid_q  <= 1'b0;
      illegal_q     <= 1'b0;
      jmp_address_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctrl_q        <= ctrl_d;
      ctrl_valid_q  <= ctrl_valid_d;
      illegal_q     <= illegal_d;
      jmp_address_q <= jmp_address_d;
    end
  end

  assign ctrl        = ctrl_q;
  assign ctrl_valid  = ctrl_valid_q;
  assign illegal     = illegal_q;
  assign jmp_address = jmp_address_q;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed test-plan sequences plus randomized traffic, all
// checked cycle by cycle against a behavioural model of issue and decode.
module tb_control_seq;

  localparam int RA     = 5;
  localparam int AW     = 32;
  localparam int MULC   = 4;
  localparam int FLUSHN = 2;
  localparam int CW     = 3*RA + 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          br_resolve = 1'b0;
  logic          br_taken = 1'b0;
  logic [CW-1:0] ctrl;
  logic          ctrl_valid;
  logic [AW-1:0] jmp_address;
  logic          illegal;

  int total = 0;
  int bad   = 0;

  control_seq #(
    .REG_ADDR_W (RA),
    .ADDR_W     (AW),
    .MUL_CYCLES (MULC),
    .FLUSH_SLOTS(FLUSHN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .br_resolve (br_resolve),
    .br_taken   (br_taken),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .jmp_address(jmp_address),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Model: stall cycles left, pending branch, slots left to discard, outputs.
  int            m_mul_left = 0;
  bit            m_br_pend  = 0;
  int            m_discard  = 0;
  logic [CW-1:0] m_ctrl     = '0;
  logic          m_valid    = 1'b0;
  logic          m_ill      = 1'b0;
  logic [AW-1:0] m_jaddr    = '0;
  logic          last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt,
                                       input int rd, input int fn);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    return w;
  endfunction

  // Reference decode from the opcode/funct tables. Flags order:
  // wr_regfile, mux_imm, alu_sel[1:0], mul_start, mux2_alu, wr_mem, cs_wb2, branch, jmp.
  function automatic void ref_dec(input logic [31:0] ins, output logic [CW-1:0] word,
                                  output bit ill, output bit is_mul, output bit is_bne,
                                  output bit is_j);
    int op, fn;
    logic [9:0]    flags;
    logic [RA-1:0] rs, rt, rd;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    rs = ins[25:21];
    rt = ins[20:16];
    rd = '0;
    ill = 0; is_mul = 0; is_bne = 0; is_j = 0;
    flags = '0;
    case (op)
      40: begin flags = 10'b1100010000; rd = rt; end
      41: begin flags = 10'b0100011000; rd = rs; end
      42: begin flags = 10'b0101010010; is_bne = 1; end
      43: begin flags = 10'b1100010100; rd = rt; end
      44: begin flags = 10'b1111010100; rd = rt; end
      2:  begin flags = 10'b0100010101; is_j = 1; end
      default: begin
        rd = ins[15:11];
        case (fn)
          32: flags = 10'b1000010100;
          34: flags = 10'b1001010100;
          36: flags = 10'b1010010100;
          37: flags = 10'b1011010100;
          50: begin flags = 10'b1000100100; is_mul = 1; end
          default: ill = 1;
        endcase
      end
    endcase
    word = ill ? '0 : {rs, rt, rd, flags};
  endfunction

  // One clock cycle: drive inputs, check ready before the edge, update the
  // model at the edge and check the registered outputs just after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic res, input logic tk);
    bit            rdy, acc, ill, im, ib, ij;
    logic [CW-1:0] w;
    instr_valid = v; instr = ins; br_resolve = res; br_taken = tk;
    rdy = (m_mul_left == 0) && !m_br_pend;
    #3;
    last_ready = instr_ready;
    chk("instr_ready", instr_ready, rdy);
    @(posedge clk);
    acc = v && rdy;
    m_ctrl = '0; m_valid = 0; m_ill = 0;
    if (m_mul_left > 0) begin
      m_mul_left--;
    end else if (m_br_pend) begin
      if (res) begin
        m_br_pend = 0;
        if (tk) m_discard = FLUSHN;
      end
    end else if (acc) begin
      if (m_discard > 0) begin
        m_discard--;
      end else begin
        ref_dec(ins, w, ill, im, ib, ij);
        m_ctrl = w; m_valid = 1; m_ill = ill;
        if (im) m_mul_left = MULC - 1;
        if (ib) m_br_pend = 1;
        if (ij) begin
          m_jaddr = AW'(ins[25:0]);
          m_discard = FLUSHN;
        end
      end
    end
    #1;
    chk("ctrl", ctrl, m_ctrl);
    chk("ctrl_valid", ctrl_valid, m_valid);
    chk("illegal", illegal, m_ill);
    chk("jmp_address", jmp_address, m_jaddr);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    instr_valid = 0; br_resolve = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_jaddr", jmp_address, 0);
    chk("rst_ready", instr_ready, 1);
    m_mul_left = 0; m_br_pend = 0; m_discard = 0;
    m_ctrl = '0; m_valid = 0; m_ill = 0; m_jaddr = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, op;
    int fns[5] = '{32, 34, 36, 37, 50};
    int ops[6] = '{40, 41, 42, 43, 44, 2};
    logic [31:0] w;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 6) begin
      w[31:26] = 6'(ops[k]);
    end else begin
      op = $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : 0;
      if (op == 2 || (op >= 40 && op <= 44)) op = 0;
      w[31:26] = 6'(op);
      if (k < 11) w[5:0] = 6'(fns[k-6]);
    end
    return w;
  endfunction

  initial begin
    int lows;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(0, '0, 0, 0);

    // Async reset, then ADD rd=3.
    do_reset();
    step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
    chk("add_rd", ctrl[14:10], 3);
    chk("add_wr", ctrl[9], 1);
    chk("add_alu", ctrl[7:6], 0);
    chk("add_wb2", ctrl[2], 1);

    // LW rt=7 then SW rs=4 back-to-back.
    step(1, mk_i(40, 1, 7, 0, 0), 0, 0);
    chk("lw_rd", ctrl[14:10], 7);
    chk("lw_wm", ctrl[3], 0);
    step(1, mk_i(41, 4, 9, 0, 0), 0, 0);
    chk("sw_valid", ctrl_valid, 1);
    chk("sw_rd", ctrl[14:10], 4);
    chk("sw_wm", ctrl[3], 1);

    // MUL with valid held high: three stall cycles, mul_start for one cycle.
    step(1, mk_i(0, 1, 2, 5, 50), 0, 0);
    chk("mul_start", ctrl[5], 1);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, mk_i(0, 1, 2, 6, 34), 0, 0);
      if (!last_ready) lows++;
      if (i == 0) chk("mul_start_once", ctrl[5], 0);
    end
    chk("mul_stall_cycles", lows, MULC - 1);

    // J 0x123: two discarded slots, third decodes.
    step(1, {6'd2, 26'h0000123}, 0, 0);
    chk("j_bit", ctrl[0], 1);
    chk("j_addr", jmp_address, 32'h123);
    step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
    chk("flush1", ctrl_valid, 0);
    step(0, '0, 0, 0);
    step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
    chk("flush2", ctrl_valid, 0);
    step(1, mk_i(0, 1, 2, 3, 36), 0, 0);
    chk("after_flush", ctrl_valid, 1);

    // BNE not taken, then taken.
    for (int t = 0; t < 2; t++) begin
      step(1, mk_i(42, 1, 2, 0, 0), 1, 1);
      chk("bne_br", ctrl[1], 1);
      step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
      step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
      chk("bne_wait_ready", last_ready, 0);
      step(1, mk_i(0, 1, 2, 3, 32), 1, t[0]);
      for (int i = 0; i < 3; i++) step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
    end

    // Illegal funct, then reset with one flush slot left.
    step(1, mk_i(0, 1, 2, 3, 63), 0, 0);
    chk("ill_pulse", illegal, 1);
    chk("ill_ctrl", ctrl, 0);
    chk("ill_valid", ctrl_valid, 1);
    step(0, '0, 0, 0);
    chk("ill_once", illegal, 0);
    step(1, {6'd2, 26'h3ffffff}, 0, 0);
    step(1, mk_i(0, 1, 2, 3, 32), 0, 0);
    do_reset();
    step(1, mk_i(0, 1, 2, 3, 37), 0, 0);
    chk("post_rst_decode", ctrl_valid, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 3, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
